// File: rtl/wallace_mul_pkg.sv
`default_nettype none
// =====================================================================
// Package  : wallace_mul_pkg
// Brief    : Shared widths, defaults and helpers for the shared multiplier.
// Revision : 1.0
// =====================================================================
package wallace_mul_pkg;

    localparam int OPW           = 4;
    localparam int PW            = 8;
    localparam int N_REQ_DEFAULT = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/w1.sv
`default_nettype none
// =====================================================================
// Module   : w1
// Brief    : Combinational 4x4 unsigned Wallace-tree multiplier.
// Revision : 1.0
// =====================================================================
module w1 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] w_pp0, w_pp1, w_pp2, w_pp3;
    logic [7:0] w_s1, w_c1, w_s2, w_c2;

    assign w_pp0 = {4'b0000, a & {4{b[0]}}};
    assign w_pp1 = {3'b000, a & {4{b[1]}}, 1'b0};
    assign w_pp2 = {2'b00, a & {4{b[2]}}, 2'b00};
    assign w_pp3 = {1'b0, a & {4{b[3]}}, 3'b000};

    // Two 3:2 carry-save layers reduce four rows to two; the final
    // adder resolves them. Product never exceeds 225, so no carry is lost.
    assign w_s1 = w_pp0 ^ w_pp1 ^ w_pp2;
    assign w_c1 = ((w_pp0 & w_pp1) | (w_pp0 & w_pp2) | (w_pp1 & w_pp2)) << 1;
    assign w_s2 = w_s1 ^ w_c1 ^ w_pp3;
    assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp3) | (w_c1 & w_pp3)) << 1;

    assign p = w_s2 + w_c2;

endmodule
`default_nettype wire

// File: rtl/wallace_mul_arbiter_rr_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker starting the search at ptr.
// Revision : 1.0
// =====================================================================
module rr_arbiter
    import wallace_mul_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);
    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wallace_mul_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : wallace_mul_arbiter
// Brief    : Round-robin sharing of one w1 multiplier, 2-stage pipeline.
// Revision : 1.0
// =====================================================================
module wallace_mul_arbiter
    import wallace_mul_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [OPW*N_REQ-1:0]   req_a,
    input  logic [OPW*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [PW-1:0]          rsp_p,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy,
    output logic [15:0]            done_cnt
);
    localparam int c_IDX_W = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);

    logic               r_op_valid;
    logic [OPW-1:0]     r_op_a;
    logic [OPW-1:0]     r_op_b;
    logic [ID_W-1:0]    r_op_id;
    logic               r_rsp_valid;
    logic [PW-1:0]      r_rsp_p;
    logic [ID_W-1:0]    r_rsp_id;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [15:0]        r_done_cnt;

    logic               w_adv;
    logic               w_acc;
    logic               w_xfer;
    logic               w_any;
    logic [N_REQ-1:0]   w_gnt;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic [c_IDX_W-1:0] w_ptr_nxt;
    logic [OPW-1:0]     w_sel_a;
    logic [OPW-1:0]     w_sel_b;
    logic [PW-1:0]      w_p;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (c_IDX_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    w1 u_mul (
        .a (r_op_a),
        .b (r_op_b),
        .p (w_p)
    );

    assign w_adv = r_op_valid & (~r_rsp_valid | rsp_ready);
    // Gating with rst_n keeps req_ready low for the whole reset window.
    assign w_acc = rst_n & (~r_op_valid | w_adv);

    assign req_ready = (w_any && w_acc) ? w_gnt : '0;
    assign w_xfer    = |req_ready;
    assign w_ptr_nxt = (w_gnt_idx == c_IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + c_IDX_W'(1);

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = req_a[i*OPW +: OPW];
                w_sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_valid  <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_p     <= '0;
            r_rsp_id    <= '0;
            r_rr_ptr    <= '0;
            r_done_cnt  <= '0;
        end else begin
            if (w_xfer) begin
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_op_id  <= ID_W'(w_gnt_idx);
                r_rr_ptr <= w_ptr_nxt;
            end
            r_op_valid <= w_xfer | (r_op_valid & ~w_adv);

            if (w_adv) begin
                r_rsp_valid <= 1'b1;
                r_rsp_p     <= w_p;
                r_rsp_id    <= r_op_id;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            if (r_rsp_valid && rsp_ready) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_p     = r_rsp_p;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_op_valid | r_rsp_valid;
    assign done_cnt  = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wallace_mul_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : tb_wallace_mul_arbiter
// Brief    : Directed self-checking bench for wallace_mul_arbiter.
// Revision : 1.0
// =====================================================================
module tb_wallace_mul_arbiter;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [4*N_REQ-1:0] req_a;
    logic [4*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [7:0]         rsp_p;
    logic [ID_W-1:0]    rsp_id;
    logic               busy;
    logic [15:0]        done_cnt;

    int n_cmp = 0;
    int n_err = 0;

    wallace_mul_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    logic [3:0] exp_gnt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] exp_p   [8] = '{8'd3, 8'd6, 8'd9, 8'd12, 8'd3, 8'd6, 8'd9, 8'd12};
    logic [1:0] exp_id  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_p",     rsp_p,     0);
        chk("rst_rsp_id",    rsp_id,    0);
        chk("rst_busy",      busy,      0);
        chk("rst_done_cnt",  done_cnt,  0);
        chk("rst_req_ready", req_ready, 0);
        req_valid = '0;
        rst_n     = 1'b1;
        #1;

        // All four requesters continuously valid: a=i+1, b=3
        for (int i = 0; i < N_REQ; i++) set_op(i, 4'(i + 1), 4'd3);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", req_ready, exp_gnt[k]);
            tick();
            if (k == 7) req_valid = '0;
            if (k == 0) chk("rr_latency_valid", rsp_valid, 0);
            if (k >= 1) begin
                chk("rr_rsp_valid", rsp_valid, 1);
                chk("rr_rsp_p",     rsp_p,     exp_p[k-1]);
                chk("rr_rsp_id",    rsp_id,    exp_id[k-1]);
            end
        end
        tick();
        chk("rr_last_p",  rsp_p,  12);
        chk("rr_last_id", rsp_id, 3);
        tick();
        chk("rr_drain_valid", rsp_valid, 0);
        chk("rr_done_cnt",    done_cnt,  8);

        // Single request on requester 2: 15*15
        set_op(2, 4'd15, 4'd15);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        chk("single_s1_valid", rsp_valid, 0);
        chk("single_s1_busy",  busy,      1);
        tick();
        chk("single_valid", rsp_valid, 1);
        chk("single_p",     rsp_p,     225);
        chk("single_id",    rsp_id,    2);
        tick();
        chk("single_done",  done_cnt,  9);
        chk("single_idle",  busy,      0);

        // Pointer is now 3: requesters 0 and 3 valid
        set_op(0, 4'd1, 4'd2);
        set_op(3, 4'd3, 4'd3);
        req_valid = 4'b1001;
        #1;
        chk("wrap_first",  req_ready, 4'b1000);
        tick();
        chk("wrap_second", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("wrap_p0",  rsp_p,  9);
        chk("wrap_id0", rsp_id, 3);
        tick();
        chk("wrap_p1",  rsp_p,  2);
        chk("wrap_id1", rsp_id, 0);
        tick();
        chk("wrap_drain", rsp_valid, 0);
        chk("wrap_done",  done_cnt,  11);

        // Only requester 1 valid: granted repeatedly
        set_op(1, 4'd4, 4'd5);
        req_valid = 4'b0010;
        #1;
        chk("solo_g0", req_ready, 4'b0010);
        tick();
        chk("solo_g1", req_ready, 4'b0010);
        tick();
        chk("solo_g2", req_ready, 4'b0010);
        chk("solo_p0", rsp_p,  20);
        chk("solo_id", rsp_id, 1);
        tick();
        req_valid = '0;
        chk("solo_p1", rsp_p, 20);
        tick();
        chk("solo_p2_valid", rsp_valid, 1);
        chk("solo_p2", rsp_p, 20);
        tick();
        chk("solo_drain", rsp_valid, 0);
        chk("solo_done",  done_cnt,  14);

        // Backpressure: rsp_ready low while requester 1 streams 4*5
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("bp_ready0", req_ready, 4'b0010);
        tick();
        chk("bp_ready1", req_ready, 4'b0010);
        tick();
        chk("bp_full_ready", req_ready, 0);
        chk("bp_full_valid", rsp_valid, 1);
        chk("bp_full_p",     rsp_p,     20);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_ready", req_ready, 0);
            chk("bp_hold_p",     rsp_p,     20);
            chk("bp_hold_done",  done_cnt,  14);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_rel_valid", rsp_valid, 1);
        chk("bp_rel_p",     rsp_p,     20);
        chk("bp_rel_done",  done_cnt,  15);
        chk("bp_rel_busy",  busy,      1);
        tick();
        chk("bp_end_valid", rsp_valid, 0);
        chk("bp_end_done",  done_cnt,  16);
        chk("bp_end_busy",  busy,      0);

        // Reset while both stages are full
        rsp_ready = 1'b0;
        set_op(3, 4'd2, 4'd2);
        req_valid = 4'b1000;
        tick();
        tick();
        req_valid = 4'hF;
        #1;
        chk("mid_pre_ready", req_ready, 0);
        chk("mid_pre_busy",  busy,      1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy",  busy,      0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_done",  done_cnt,  0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_first_grant", req_ready, 4'b0001);
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        chk("mid_p",  rsp_p,  2);
        chk("mid_id", rsp_id, 0);
        tick();
        chk("mid_done", done_cnt, 1);

        // Exhaustive 16x16 through requester N_REQ-1
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("exh_start_done", done_cnt, 0);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [7:0] prod;
                prod = 8'(a * b);
                set_op(N_REQ - 1, 4'(a), 4'(b));
                req_valid = 4'b1000;
                tick();
                req_valid = '0;
                tick();
                chk("exh_p",  rsp_p,  prod);
                chk("exh_id", rsp_id, N_REQ - 1);
                tick();
            end
        end
        chk("exh_done", done_cnt, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wallace_mul_arbiter.md
Name: wallace_mul_arbiter

Overview:
- Shares one instance of the team's combinational 4x4 Wallace-tree multiplier `w1` (ports a[3:0], b[3:0], p[7:0]) among N_REQ requesters.
- Arbitration is round-robin, with a valid/ready handshake on every request port.
- Wraps the multiplier in a 2-stage registered pipeline: operand register, then result register.
- Returns each product tagged with the originating requester ID, on a single backpressured response port.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_a  input  4*N_REQ  operand A; requester i uses bits [4i+3:4i].
- req_b  input  4*N_REQ  operand B; same packing as req_a.
- req_ready  output  N_REQ  one-hot (or zero) grant/accept.
- rsp_valid  output  1  result register holds a valid product.
- rsp_ready  input  1  downstream accepts the response.
- rsp_p  output  8  product a*b.
- rsp_id  output  ID_W  index of the requester that issued the operands.
- busy  output  1  high when op_valid or rsp_valid is set.
- done_cnt  output  16  count of completed responses; wraps at 16'hFFFF -> 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: op_valid=0, rsp_valid=0, rsp_p=0, rsp_id=0, rr_ptr=0, done_cnt=0. Therefore req_ready=0 and busy=0.
- Stage S1 (operand register): op_valid, op_a, op_b, op_id.
- Stage S2 (result register): rsp_valid, rsp_p, rsp_id.
- rsp_p <= w1.p driven from op_a/op_b, registered into S2.
- Control equations:
  - adv = op_valid & (!rsp_valid | rsp_ready) -> S1 moves into S2.
  - acc = !op_valid | adv -> S1 can take a new request.
- Arbitration:
  - Combinational, over req_valid.
  - Search order starts at rr_ptr and wraps from N_REQ-1 to 0.
  - The first set bit wins; the winner index is g.
- req_ready[g] = acc & req_valid[g]. All other bits are 0. req_ready is combinational from req_valid.
- Transfer on requester i occurs when req_valid[i] & req_ready[i]. Then:
  - S1 loads that requester's operands and op_id=i.
  - rr_ptr <= (i+1) mod N_REQ.
- rr_ptr is unchanged in any cycle with no transfer.
- Requester obligations: hold req_valid and operands stable until the transfer. Dropping valid early is permitted; the request is simply not taken.
- S1 valid update: op_valid <= transfer | (op_valid & !adv).
- S2 update:
  - On adv: rsp_valid <= 1 and load rsp_p/rsp_id.
  - Else if rsp_ready: rsp_valid <= 0.
- Response handshake: when rsp_valid & rsp_ready, done_cnt increments.
- Latency: a transfer at edge t gives rsp_valid high after edge t+1, so the response is visible in cycle t+1 to t+2.
- Throughput: 1 result/cycle with rsp_ready held high.
- Stall: with rsp_valid=1 and rsp_ready=0, S2 holds, S1 holds if full, and req_ready=0 once S1 is full. At most 2 results are in flight.
- Simultaneous events:
  - Same-cycle S2 drain + S1 advance + new transfer is legal. No bubble is inserted.
- Response ordering: responses leave in grant order; no reordering.
- No starvation: with all N_REQ requesters continuously valid, each is granted exactly once per N_REQ transfers.
- Reset mid-operation: in-flight S1/S2 contents are discarded with no response emitted, and rr_ptr returns to 0.
- Width rules: operands are unsigned. 15*15=225 fits in 8 bits, so no overflow handling is needed.

Decomposition:
- Shared package wallace_mul_pkg holds:
  - OPW=4 and PW=8;
  - default N_REQ;
  - function clog2 for ID_W checks.
- One natural sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req[N-1:0], ptr.
  - Outputs: one-hot gnt, gnt_idx, any.
- The multiplier is an instance of the existing w1. No functional change to w1.

Test Plan:
- Single request: req 2 with a=15, b=15; rsp_ready=1 -> req_ready[2] high the same cycle; two cycles later rsp_valid=1, rsp_p=225, rsp_id=2; done_cnt=1.
- All 4 requesters continuously valid with a=i+1, b=3; rsp_ready=1 -> grants in order 0,1,2,3,0,…; products 3,6,9,12 back-to-back at 1/cycle.
- Backpressure: rsp_ready=0 for 5 cycles with req 1 streaming a=4, b=5 -> two results latched, then req_ready=0; on rsp_ready=1 rsp_p=20 is delivered twice with no loss or duplication.
- rr_ptr=3 with reqs 0 and 3 valid -> 3 granted first, then 0; with only req 1 valid -> 1 granted repeatedly.
- Reset mid-flight: assert rst_n=0 asynchronously while S1 and S2 are full -> rsp_valid, req_ready, busy go 0 immediately; after release the first grant goes to req 0.
- Exhaustive: all 256 (a,b) pairs via requester N_REQ-1 -> rsp_p == a*b and rsp_id == N_REQ-1 for every pair; done_cnt=256.
